ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (optional watchdog: PS2_HOST_TX_TIMEOUT_EN)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [2:0]       data_sync_q, data_sync_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             parity_q, parity_d;
    logic             err_q, err_d;
    logic             init_q, init_d;
    logic             clk_fall;
    logic             cur_bit;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             wd_active;
`endif

    assign clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    assign data_sync_d = {data_sync_q[1:0], ps2_data};
    assign clk_fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign init_d      = 1'b1;

    // Bit presented on the data line after falling edge n of the frame.
    always_comb begin
        cur_bit = parity_q;
        case (edge_cnt_q)
            4'd1:    cur_bit = byte_q[0];
            4'd2:    cur_bit = byte_q[1];
            4'd3:    cur_bit = byte_q[2];
            4'd4:    cur_bit = byte_q[3];
            4'd5:    cur_bit = byte_q[4];
            4'd6:    cur_bit = byte_q[5];
            4'd7:    cur_bit = byte_q[6];
            4'd8:    cur_bit = byte_q[7];
            default: cur_bit = parity_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        inh_cnt_d   = inh_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        byte_d      = byte_q;
        parity_d    = parity_q;
        err_d       = err_q;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_ready    = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_ready = init_q;
                if (tx_valid && init_q) begin
                    byte_d    = tx_data;
                    parity_d  = ~^tx_data;
                    inh_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt_q == INH_LAST) begin
                    ps2_data_oe = 1'b1;
                    inh_cnt_d   = '0;
                    state_d     = S_RELEASE;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                ps2_data_oe = 1'b1;
                if (clk_fall) begin
                    edge_cnt_d = 4'd1;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ps2_data_oe = ~cur_bit;
                if (clk_fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (edge_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                // Stop bit is the released line; the 11th fall samples the device ack.
                if (clk_fall) begin
                    err_d   = data_sync_q[1];
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q[2] && data_sync_q[2]) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                tx_done    = 1'b1;
                tx_err     = err_q;
                err_d      = 1'b0;
                edge_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        wd_d = '0;
        if (wd_active) begin
            if (wd_q == WD_LAST) begin
                err_d   = 1'b1;
                state_d = S_FINISH;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    assign wd_active = (state_q == S_RELEASE) || (state_q == S_SHIFT) ||
                       (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
            inh_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            byte_q      <= '0;
            parity_q    <= 1'b0;
            err_q       <= 1'b0;
            init_q      <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            inh_cnt_q   <= inh_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            byte_q      <= byte_d;
            parity_q    <= parity_d;
            err_q       <= err_d;
            init_q      <= init_d;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

endmodule
